// File: rtl/bf16_arb_pkg.sv
// Shared types and constants for the BF16 unit arbiter.
package bf16_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [15:0] BF16_CANON_NAN = 16'h7FC0;
    localparam int          OPC_W          = 2;

endpackage

// File: rtl/bf16_arbiter_if.sv
// Requester-side and BF16Unit-side signal bundle; master is the arbiter, slave its environment.
interface bf16_arbiter_if
    import bf16_arb_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [OPC_W*N_REQ-1:0] req_opc;
    logic [16*N_REQ-1:0]    req_a;
    logic [16*N_REQ-1:0]    req_b;
    logic [N_REQ-1:0]       req_is_sqrt;
    logic [N_REQ-1:0]       req_kill;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [15:0]            rsp_y;
    logic                   rsp_err;

    logic [OPC_W-1:0]       bf16_opc;
    logic [15:0]            bf16_a;
    logic [15:0]            bf16_b;
    logic                   bf16_isSqrt;
    logic                   bf16_iv;
    logic                   bf16_ir;
    logic                   bf16_ov;
    logic                   bf16_or;
    logic [15:0]            bf16_y;
    logic                   bf16_kill;

    logic [IDX_W-1:0]       grant_id;
    logic                   busy;

    modport master (
        input  req_valid, req_opc, req_a, req_b, req_is_sqrt, req_kill, rsp_ready,
        input  bf16_ir, bf16_ov, bf16_y,
        output req_ready, rsp_valid, rsp_y, rsp_err,
        output bf16_opc, bf16_a, bf16_b, bf16_isSqrt, bf16_iv, bf16_or, bf16_kill,
        output grant_id, busy
    );

    modport slave (
        output req_valid, req_opc, req_a, req_b, req_is_sqrt, req_kill, rsp_ready,
        output bf16_ir, bf16_ov, bf16_y,
        input  req_ready, rsp_valid, rsp_y, rsp_err,
        input  bf16_opc, bf16_a, bf16_b, bf16_isSqrt, bf16_iv, bf16_or, bf16_kill,
        input  grant_id, busy
    );

endinterface

// File: rtl/bf16_arbiter_rr_arbiter.sv
// Round-robin selector: first set request at or above ptr, wrapping N_REQ-1 -> 0.
module rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0] cand_idx [N_REQ];

    // cand_idx[k] = (ptr + k) mod N_REQ, the k-th requester in search order
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum          = {1'b0, ptr} + SUM_W'(gi);
        assign cand_idx[gi] = (sum >= SUM_W'(N_REQ)) ? IDX_W'(sum - SUM_W'(N_REQ))
                                                     : sum[IDX_W-1:0];
    end

    always_comb begin
        any   = 1'b0;
        idx   = '0;
        grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[cand_idx[k]]) begin
                any = 1'b1;
                idx = cand_idx[k];
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bf16_arbiter.sv
// Shares one BF16Unit among N_REQ requesters, one operation in flight, with
// owner kill, timeout abort and round-robin fairness.
module bf16_arbiter
    import bf16_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    bf16_arbiter_if.master bus
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               sqrt_q, sqrt_d;
    logic [15:0]        rsp_y_q, rsp_y_d;
    logic               rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [OPC_W-1:0]   opc_arr [N_REQ];
    logic [15:0]        a_arr   [N_REQ];
    logic [15:0]        b_arr   [N_REQ];

    logic [N_REQ-1:0]   req_ready_c, rsp_valid_c;
    logic               iv_c, or_c, kill_c;
    logic               owner_kill;
    logic [IDX_W-1:0]   next_owner;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign opc_arr[gi] = bus.req_opc[gi*OPC_W +: OPC_W];
        assign a_arr[gi]   = bus.req_a[gi*16 +: 16];
        assign b_arr[gi]   = bus.req_b[gi*16 +: 16];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign owner_kill = bus.req_kill[owner_q];
    assign next_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        opc_d       = opc_q;
        a_d         = a_q;
        b_d         = b_q;
        sqrt_d      = sqrt_q;
        rsp_y_d     = rsp_y_q;
        rsp_err_d   = rsp_err_q;
        req_ready_c = '0;
        rsp_valid_c = '0;
        iv_c        = 1'b0;
        or_c        = 1'b0;
        kill_c      = 1'b0;

        // Outputs stay quiet while reset is held, even if state_q is mid-operation.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        req_ready_c = arb_grant;
                        owner_d     = arb_idx;
                        opc_d       = opc_arr[arb_idx];
                        a_d         = a_arr[arb_idx];
                        b_d         = b_arr[arb_idx];
                        sqrt_d      = bus.req_is_sqrt[arb_idx];
                        state_d     = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    iv_c = 1'b1;
                    if (owner_kill) begin
                        kill_c   = 1'b1;
                        rr_ptr_d = next_owner;
                        state_d  = ST_IDLE;
                    end else if (bus.bf16_ir) begin
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    or_c = 1'b1;
                    // Kill and timeout both take precedence over a coincident result.
                    if (owner_kill) begin
                        kill_c   = 1'b1;
                        rr_ptr_d = next_owner;
                        state_d  = ST_IDLE;
                    end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                        kill_c    = 1'b1;
                        rsp_y_d   = BF16_CANON_NAN;
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else if (bus.bf16_ov) begin
                        rsp_y_d   = bus.bf16_y;
                        rsp_err_d = 1'b0;
                        state_d   = ST_RESP;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                ST_RESP: begin
                    if (owner_kill) begin
                        rr_ptr_d = next_owner;
                        state_d  = ST_IDLE;
                    end else begin
                        rsp_valid_c[owner_q] = 1'b1;
                        if (bus.rsp_ready[owner_q]) begin
                            rr_ptr_d = next_owner;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            opc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sqrt_q    <= 1'b0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            opc_q     <= opc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sqrt_q    <= sqrt_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_y       = rsp_y_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.bf16_opc    = opc_q;
    assign bus.bf16_a      = a_q;
    assign bus.bf16_b      = b_q;
    assign bus.bf16_isSqrt = sqrt_q;
    assign bus.bf16_iv     = iv_c;
    assign bus.bf16_or     = or_c;
    assign bus.bf16_kill   = kill_c;
    assign bus.grant_id    = owner_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bf16_arbiter.sv
// Directed bench for bf16_arbiter: vector table of single operations plus
// timeout, kill and reset sequences against a stub BF16Unit driven inline.
module tb_bf16_arbiter;
    import bf16_arb_pkg::*;

    localparam int N       = 4;
    localparam int TMO     = 255;
    localparam int N_VEC   = 14;

    typedef struct {
        logic [3:0]  mask;
        int          grant;
        logic [1:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        sqrt;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   op_no    = 0;
    vec_t vecs [N_VEC];

    bf16_arbiter_if #(.N_REQ(N)) bus ();

    bf16_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] stub_y(logic [1:0] opc, logic [15:0] a, logic [15:0] b, logic s);
        return a ^ {b[7:0], b[15:8]} ^ {s, 13'h0, opc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Winner slot gets the vector operands; every other slot gets their complement.
    task automatic drive_slices(input int g, input logic [1:0] opc, input logic [15:0] a,
                                input logic [15:0] b, input logic s);
        for (int i = 0; i < N; i++) begin
            bus.req_opc[i*2 +: 2]  = (i == g) ? opc : ~opc;
            bus.req_a[i*16 +: 16]  = (i == g) ? a : ~a;
            bus.req_b[i*16 +: 16]  = (i == g) ? b : ~b;
            bus.req_is_sqrt[i]     = (i == g) ? s : ~s;
        end
    endtask

    // Entered and left at a negedge with the arbiter in IDLE.
    task automatic run_op(input vec_t v);
        logic [3:0]  onehot;
        logic [15:0] y;
        onehot = 4'b0001 << v.grant;
        y      = stub_y(v.opc, v.a, v.b, v.sqrt);
        bus.req_valid = v.mask;
        drive_slices(v.grant, v.opc, v.a, v.b, v.sqrt);
        #1;
        check("req_ready", 64'(bus.req_ready), 64'(onehot));
        @(negedge clk); #1;
        check("issue_iv", 64'(bus.bf16_iv), 64'd1);
        check("issue_ready_clear", 64'(bus.req_ready), 64'd0);
        check("grant_id", 64'(bus.grant_id), 64'(v.grant));
        check("bf16_a", 64'(bus.bf16_a), 64'(v.a));
        check("bf16_b", 64'(bus.bf16_b), 64'(v.b));
        check("bf16_opc", 64'(bus.bf16_opc), 64'(v.opc));
        check("bf16_isSqrt", 64'(bus.bf16_isSqrt), 64'(v.sqrt));
        repeat (v.lat) begin
            @(negedge clk); #1;
            check("issue_stall_iv", 64'(bus.bf16_iv), 64'd1);
            check("issue_stall_a", 64'(bus.bf16_a), 64'(v.a));
        end
        bus.bf16_ir = 1'b1;
        @(negedge clk);
        bus.bf16_ir = 1'b0;
        #1;
        check("wait_or", 64'(bus.bf16_or), 64'd1);
        check("wait_iv", 64'(bus.bf16_iv), 64'd0);
        repeat (v.lat) @(negedge clk);
        bus.bf16_ov = 1'b1;
        bus.bf16_y  = y;
        @(negedge clk);
        bus.bf16_ov = 1'b0;
        #1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(onehot));
        check("rsp_y", 64'(bus.rsp_y), 64'(y));
        check("rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rsp_no_kill", 64'(bus.bf16_kill), 64'd0);
        bus.rsp_ready = onehot;
        @(negedge clk);
        bus.rsp_ready = '0;
        #1;
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        $display("op %0d: mask=%b grant=%0d a=%h b=%h y=%h", op_no, v.mask, bus.grant_id, v.a, v.b, bus.rsp_y);
        op_no++;
    endtask

    initial begin
        int   seen;
        vec_t vr;

        vecs[0]  = '{4'b0010, 1, 2'd0, 16'h3F80, 16'h4000, 1'b0, 0};
        vecs[1]  = '{4'b0001, 0, 2'd1, 16'h4040, 16'h3F00, 1'b0, 1};
        vecs[2]  = '{4'b1100, 2, 2'd2, 16'hC000, 16'h4110, 1'b1, 2};
        vecs[3]  = '{4'b1001, 3, 2'd3, 16'h0001, 16'h8000, 1'b0, 0};
        vecs[4]  = '{4'b1001, 0, 2'd0, 16'h7F7F, 16'h0080, 1'b1, 3};
        vecs[5]  = '{4'b1000, 3, 2'd1, 16'h4120, 16'h4120, 1'b0, 0};
        vecs[6]  = '{4'b1111, 0, 2'd0, 16'h1111, 16'h2222, 1'b0, 0};
        vecs[7]  = '{4'b1111, 1, 2'd1, 16'h3333, 16'h4444, 1'b1, 1};
        vecs[8]  = '{4'b1111, 2, 2'd2, 16'h5555, 16'h6666, 1'b0, 0};
        vecs[9]  = '{4'b1111, 3, 2'd3, 16'h7777, 16'h8888, 1'b1, 2};
        vecs[10] = '{4'b1111, 0, 2'd1, 16'h9999, 16'hAAAA, 1'b0, 0};
        vecs[11] = '{4'b1111, 1, 2'd2, 16'hBBBB, 16'hCCCC, 1'b0, 1};
        vecs[12] = '{4'b1111, 2, 2'd3, 16'hDDDD, 16'hEEEE, 1'b1, 0};
        vecs[13] = '{4'b1111, 3, 2'd0, 16'hFFFF, 16'h0F0F, 1'b0, 0};

        bus.req_valid   = 4'b1111;
        bus.req_opc     = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_is_sqrt = '0;
        bus.req_kill    = '0;
        bus.rsp_ready   = '0;
        bus.bf16_ir     = 1'b0;
        bus.bf16_ov     = 1'b0;
        bus.bf16_y      = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        check("rst_iv", 64'(bus.bf16_iv), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            run_op(vecs[i]);
        end

        // Timeout: the unit never answers; a result arriving with the abort is discarded.
        bus.req_valid = 4'b0100;
        drive_slices(2, 2'd1, 16'h4000, 16'h4000, 1'b0);
        #1;
        check("tmo_req_ready", 64'(bus.req_ready), 64'b0100);
        @(negedge clk);
        bus.bf16_ir = 1'b1;
        @(negedge clk);
        bus.bf16_ir   = 1'b0;
        bus.req_valid = '0;
        seen = -1;
        for (int c = 0; c < 300; c++) begin
            if (c == TMO) begin
                bus.bf16_ov = 1'b1;
                bus.bf16_y  = 16'h1234;
            end
            #1;
            if (bus.bf16_kill) begin
                seen = c;
                break;
            end
            @(negedge clk);
        end
        check("tmo_kill_cycle", 64'(seen), 64'(TMO));
        @(negedge clk);
        bus.bf16_ov = 1'b0;
        #1;
        check("tmo_kill_single", 64'(bus.bf16_kill), 64'd0);
        check("tmo_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
        check("tmo_rsp_y", 64'(bus.rsp_y), 64'(BF16_CANON_NAN));
        check("tmo_rsp_err", 64'(bus.rsp_err), 64'd1);
        bus.rsp_ready = 4'b0100;
        @(negedge clk);
        bus.rsp_ready = '0;
        #1;
        check("tmo_idle_busy", 64'(bus.busy), 64'd0);
        $display("op %0d: timeout grant=2 kill_at_wait_cycle=%0d y=%h err=%b", op_no, seen, bus.rsp_y, bus.rsp_err);
        op_no++;

        // Kill: pointer is 3, so 0011 goes to requester 0; requester 1's kill is ignored.
        bus.req_valid = 4'b0011;
        drive_slices(0, 2'd2, 16'h3C00, 16'h3E00, 1'b0);
        #1;
        check("kill_req_ready", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.bf16_ir = 1'b1;
        @(negedge clk);
        bus.bf16_ir  = 1'b0;
        bus.req_kill = 4'b0010;
        #1;
        check("nonowner_kill", 64'(bus.bf16_kill), 64'd0);
        check("nonowner_or", 64'(bus.bf16_or), 64'd1);
        @(negedge clk);
        bus.req_kill = 4'b0001;
        #1;
        check("owner_kill", 64'(bus.bf16_kill), 64'd1);
        check("owner_kill_rsp", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        bus.req_kill = '0;
        #1;
        check("kill_busy", 64'(bus.busy), 64'd0);
        check("kill_pulse_end", 64'(bus.bf16_kill), 64'd0);
        check("kill_no_rsp", 64'(bus.rsp_valid), 64'd0);
        check("kill_next_grant", 64'(bus.req_ready), 64'b0010);
        $display("op %0d: owner kill grant=0, next grant req_ready=%b", op_no, bus.req_ready);
        op_no++;

        // Reset in WAIT with requester 1 owning the unit.
        @(negedge clk);
        bus.bf16_ir = 1'b1;
        #1;
        check("rstw_grant_id", 64'(bus.grant_id), 64'd1);
        @(negedge clk);
        bus.bf16_ir = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstw_busy", 64'(bus.busy), 64'd0);
        check("rstw_grant_id0", 64'(bus.grant_id), 64'd0);
        check("rstw_kill", 64'(bus.bf16_kill), 64'd0);
        check("rstw_or", 64'(bus.bf16_or), 64'd0);
        check("rstw_iv", 64'(bus.bf16_iv), 64'd0);
        check("rstw_req_ready", 64'(bus.req_ready), 64'd0);
        check("rstw_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rstw_bf16_a", 64'(bus.bf16_a), 64'd0);
        check("rstw_rsp_y", 64'(bus.rsp_y), 64'd0);
        rst = 1'b0;
        vr = '{4'b1111, 0, 2'd3, 16'hBF80, 16'h3F80, 1'b1, 1};
        run_op(vr);
        bus.req_valid = '0;

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bf16_arbiter.md
BF16_ARBITER -- requirements
Module: bf16_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one BF16Unit (range 2..8).
REQ-002 Parameter: TIMEOUT, 255, maximum cycles in WAIT before forced abort.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  N_REQ  per-requester operation request.
REQ-006 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-007 req_opc  in  2*N_REQ  opcode, slice i belongs to requester i.
REQ-008 req_a / req_b  in  16*N_REQ  BF16 operands, slice i per requester.
REQ-009 req_is_sqrt  in  N_REQ  sqrt qualifier per requester.
REQ-010 req_kill  in  N_REQ  abort own in-flight operation.
REQ-011 rsp_valid  out  N_REQ  result valid, one-hot or zero.
REQ-012 rsp_ready  in  N_REQ  result accept per requester.
REQ-013 rsp_y  out  16  result data, shared by all requesters.
REQ-014 rsp_err  out  1  result produced by timeout, qualified by rsp_valid.
REQ-015 bf16_opc / bf16_a / bf16_b / bf16_isSqrt  out  2/16/16/1  to BF16Unit.
REQ-016 bf16_iv  out 1; bf16_ir  in 1; bf16_ov  in 1; bf16_or  out 1; bf16_y  in 16; bf16_kill  out 1  BF16Unit handshake.
REQ-017 grant_id  out  clog2(N_REQ)  current owner index; busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-019 IDLE: if any req_valid, select winner round-robin starting at rr_ptr, searching upward and wrapping N_REQ-1 -> 0; pulse req_ready[winner] for that cycle; latch opc/a/b/isSqrt and owner; next state ISSUE.
REQ-020 ISSUE: bf16_iv=1 with latched operands held stable; on bf16_iv && bf16_ir go to WAIT, clear timer.
REQ-021 WAIT: bf16_or=1; on bf16_ov capture bf16_y into rsp_y, rsp_err=0, go to RESP.
REQ-022 WAIT: timer increments each cycle; on reaching TIMEOUT, pulse bf16_kill one cycle, rsp_y=16'h7FC0, rsp_err=1, go to RESP.
REQ-023 RESP: rsp_valid[owner]=1, rsp_y/rsp_err held; on rsp_ready[owner] set rr_ptr=(owner+1) mod N_REQ and go to IDLE.
REQ-024 req_kill[owner] in ISSUE or WAIT: pulse bf16_kill one cycle, no response, rr_ptr=(owner+1) mod N_REQ, go to IDLE; in RESP: drop response, same transitions.
REQ-025 req_kill from a non-owner SHALL be ignored.
REQ-026 bf16_ov in WAIT coincident with timeout or owner kill: kill wins, result discarded.
REQ-027 bf16_iv, bf16_or, bf16_kill, rsp_valid, req_ready SHALL be zero outside the states named above.
REQ-028 Latency: accept at cycle 0, bf16_iv at cycle 1, rsp_valid the cycle after bf16_ov.
REQ-029 Back-to-back: earliest next req_ready SHALL be the cycle after rsp handshake (IDLE re-entry).

Reset
REQ-030 rst SHALL force IDLE, rr_ptr=0, timer=0, owner=0, and all outputs to 0, including mid-operation; no bf16_kill is issued by reset.

Structure
REQ-031 Package bf16_arb_pkg SHALL hold the state enum, BF16 canonical-NaN constant 16'h7FC0, and opcode width 2.
REQ-032 Sub-module rr_arbiter (req vector, pointer -> one-hot grant, index) SHALL implement REQ-019 selection; the rest stays in bf16_arbiter.

Verification
REQ-033 Single request: req_valid=4'b0010, a=16'h3F80, b=16'h4000, opc=2'd0 -> req_ready=4'b0010, bf16_a/b match, rsp_valid=4'b0010 with rsp_y = model output, grant_id=1.
REQ-034 Round-robin: all four req_valid held high for 8 ops -> grant order 0,1,2,3,0,1,2,3.
REQ-035 Wrap: rr_ptr=3, req_valid=4'b1001 -> grant 3 then 0.
REQ-036 Timeout: BF16 model never asserts bf16_ov -> bf16_kill pulse at WAIT cycle 255, rsp_y=16'h7FC0, rsp_err=1.
REQ-037 Owner kill in WAIT -> one-cycle bf16_kill, no rsp_valid, busy=0 next cycle; non-owner kill -> no effect.
REQ-038 rst asserted in WAIT -> next cycle all outputs 0, busy=0, next grant begins at requester 0.
